// File: rtl/control_ventilacion.sv
// Sampled-temperature fan/alarm controller feeding the 7-segment activation stage.
// Each threshold crossing is confirmed over N_CONF consecutive strobes; the alarm latches until acknowledged.
module control_ventilacion #(
  parameter int W          = 5,
  parameter int T_VENT_ON  = 20,
  parameter int T_VENT_OFF = 17,
  parameter int T_ALARMA   = 26,
  parameter int N_CONF     = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         muestra,
  input  logic [W-1:0] temp,
  input  logic         acuse,
  output logic         Ventilacion,
  output logic         Alarma,
  output logic [1:0]   estado
);

  typedef enum logic [1:0] {
    REPOSO     = 2'b00,
    VENTILANDO = 2'b01,
    ALARMA     = 2'b10
  } state_t;

  localparam logic [W-1:0] TH_ON     = W'(T_VENT_ON);
  localparam logic [W-1:0] TH_OFF    = W'(T_VENT_OFF);
  localparam logic [W-1:0] TH_ALARMA = W'(T_ALARMA);
  localparam logic [2:0]   N_C       = 3'(N_CONF);

  logic [2:0] cnt_sube;
  logic [2:0] cnt_baja;

  logic       ge_on;
  logic       ge_alarma;
  logic       le_off;
  logic [2:0] sube_inc;
  logic [2:0] baja_inc;
  logic       sube_full;
  logic       baja_full;

  assign ge_on     = (temp >= TH_ON);
  assign ge_alarma = (temp >= TH_ALARMA);
  assign le_off    = (temp <= TH_OFF);

  // Saturating increments; reaching N_C on this sample means the transition fires now.
  assign sube_inc  = (cnt_sube >= N_C) ? N_C : cnt_sube + 3'd1;
  assign baja_inc  = (cnt_baja >= N_C) ? N_C : cnt_baja + 3'd1;
  assign sube_full = (sube_inc == N_C);
  assign baja_full = (baja_inc == N_C);

  // NOTE: every register here is assigned with <= so all reads in this block see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado      <= REPOSO;
      Ventilacion <= 1'b0;
      Alarma      <= 1'b0;
      cnt_sube    <= '0;
      cnt_baja    <= '0;
    end else begin
      case (estado)
        REPOSO: begin
          if (muestra) begin
            cnt_baja <= '0;
            if (ge_on) begin
              if (sube_full) begin
                estado      <= VENTILANDO;
                Ventilacion <= 1'b1;
                Alarma      <= 1'b0;
                cnt_sube    <= '0;
              end else begin
                cnt_sube <= sube_inc;
              end
            end else begin
              cnt_sube <= '0;
            end
          end
        end

        VENTILANDO: begin
          if (muestra) begin
            if (ge_alarma) begin
              cnt_baja <= '0;
              if (sube_full) begin
                estado      <= ALARMA;
                Ventilacion <= 1'b0;
                Alarma      <= 1'b1;
                cnt_sube    <= '0;
              end else begin
                cnt_sube <= sube_inc;
              end
            end else if (le_off) begin
              cnt_sube <= '0;
              if (baja_full) begin
                estado      <= REPOSO;
                Ventilacion <= 1'b0;
                Alarma      <= 1'b0;
                cnt_baja    <= '0;
              end else begin
                cnt_baja <= baja_inc;
              end
            end else begin
              cnt_sube <= '0;
              cnt_baja <= '0;
            end
          end
        end

        ALARMA: begin
          cnt_sube <= '0;
          cnt_baja <= '0;
          if (muestra && acuse && !ge_alarma) begin
            estado      <= VENTILANDO;
            Ventilacion <= 1'b1;
            Alarma      <= 1'b0;
          end
        end

        // NOTE: the unused code 11 must recover on the next edge, independent of muestra.
        default: begin
          estado      <= REPOSO;
          Ventilacion <= 1'b0;
          Alarma      <= 1'b0;
          cnt_sube    <= '0;
          cnt_baja    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_ventilacion.sv
// Self-checking bench for control_ventilacion: directed scenarios plus randomized
// stimulus compared against a sample-history reference model.
module tb_control_ventilacion;

  localparam int W     = 5;
  localparam int T_ON  = 20;
  localparam int T_OFF = 17;
  localparam int T_AL  = 26;
  localparam int N     = 4;

  logic         clk = 1'b0;
  logic         reset, muestra, acuse;
  logic [W-1:0] temp;
  logic         vent, alarma;
  logic [1:0]   estado;

  logic         reset1, muestra1, acuse1;
  logic [W-1:0] temp1;
  logic         vent1, alarma1;
  logic [1:0]   estado1;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  control_ventilacion #(.W(W), .T_VENT_ON(T_ON), .T_VENT_OFF(T_OFF), .T_ALARMA(T_AL), .N_CONF(N)) dut (
    .clk(clk), .reset(reset), .muestra(muestra), .temp(temp), .acuse(acuse),
    .Ventilacion(vent), .Alarma(alarma), .estado(estado)
  );

  control_ventilacion #(.W(W), .T_VENT_ON(T_ON), .T_VENT_OFF(T_OFF), .T_ALARMA(T_AL), .N_CONF(1)) dut1 (
    .clk(clk), .reset(reset1), .muestra(muestra1), .temp(temp1), .acuse(acuse1),
    .Ventilacion(vent1), .Alarma(alarma1), .estado(estado1)
  );

  // Reference model: mode 0 idle, 1 fan, 2 alarm; history holds the samples seen since the last mode change.
  int          m_mode;
  int unsigned m_hist[$];

  function automatic bit cond(input int kind, input int unsigned t);
    case (kind)
      0:       return t >= T_ON;
      1:       return t >= T_AL;
      default: return t <= T_OFF;
    endcase
  endfunction

  function automatic bit last_n(input int kind, input int n);
    if (m_hist.size() < n) return 1'b0;
    for (int i = m_hist.size() - n; i < m_hist.size(); i++)
      if (!cond(kind, m_hist[i])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int run_len(input int kind, input int n);
    int r = 0;
    for (int i = m_hist.size() - 1; i >= 0; i--) begin
      if (!cond(kind, m_hist[i]) || r == n) break;
      r++;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_hist.delete();
  endtask

  task automatic model_step(input bit m, input int unsigned t, input bit a);
    if (!m) return;
    case (m_mode)
      0: begin
        m_hist.push_back(t);
        if (last_n(0, N)) begin m_mode = 1; m_hist.delete(); end
      end
      1: begin
        m_hist.push_back(t);
        if (last_n(1, N))      begin m_mode = 2; m_hist.delete(); end
        else if (last_n(2, N)) begin m_mode = 0; m_hist.delete(); end
      end
      default: begin
        if (a && t < T_AL) begin m_mode = 1; m_hist.delete(); end
      end
    endcase
  endtask

  task automatic cycle(input bit m, input int unsigned t, input bit a);
    muestra = m;
    temp    = t[W-1:0];
    acuse   = a;
    @(posedge clk);
    #1;
    model_step(m, t, a);
  endtask

  task automatic test_reset();
    reset = 1'b1; muestra = 1'b0; temp = '0; acuse = 1'b0;
    reset1 = 1'b1; muestra1 = 1'b0; temp1 = '0; acuse1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({estado, vent, alarma, dut.cnt_sube, dut.cnt_baja} !== 10'b0) begin
      $display("FAIL reset_state: got %b expected %b", {estado, vent, alarma, dut.cnt_sube, dut.cnt_baja}, 10'b0);
    end else passed++;
    reset = 1'b0;
    reset1 = 1'b0;
    model_reset();
  endtask

  task automatic test_turn_on();
    int unsigned seq[8]  = '{22, 22, 22, 18, 22, 22, 22, 22};
    logic [2:0]  exp_c[8] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    logic [3:0]  exp_s;
    for (int i = 0; i < 8; i++) begin
      exp_s = (i == 7) ? 4'b0110 : 4'b0000;
      cycle(1'b1, seq[i], 1'b0);
      checks++;
      if ({estado, vent, alarma} !== exp_s || dut.cnt_sube !== exp_c[i]) begin
        $display("FAIL turn_on sample %0d: got st=%b cnt=%0d expected st=%b cnt=%0d",
                 i + 1, {estado, vent, alarma}, dut.cnt_sube, exp_s, exp_c[i]);
      end else passed++;
      cycle(1'b0, 31, 1'b1);
      checks++;
      if ({estado, vent, alarma} !== exp_s || dut.cnt_sube !== exp_c[i]) begin
        $display("FAIL turn_on idle %0d: got st=%b cnt=%0d expected st=%b cnt=%0d",
                 i + 1, {estado, vent, alarma}, dut.cnt_sube, exp_s, exp_c[i]);
      end else passed++;
    end
  endtask

  task automatic test_hysteresis();
    int unsigned seq[7]   = '{17, 17, 18, 17, 17, 17, 17};
    logic [2:0]  exp_c[7] = '{3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    logic [3:0]  exp_s;
    for (int i = 0; i < 7; i++) begin
      exp_s = (i == 6) ? 4'b0000 : 4'b0110;
      cycle(1'b1, seq[i], 1'b0);
      checks++;
      if ({estado, vent, alarma} !== exp_s || dut.cnt_baja !== exp_c[i]) begin
        $display("FAIL hysteresis sample %0d: got st=%b cnt_baja=%0d expected st=%b cnt_baja=%0d",
                 i + 1, {estado, vent, alarma}, dut.cnt_baja, exp_s, exp_c[i]);
      end else passed++;
    end
  endtask

  task automatic test_alarm();
    int unsigned hot[4] = '{30, 30, 30, 25};
    logic [3:0]  exp_s;
    repeat (4) cycle(1'b1, 22, 1'b0);
    checks++;
    if ({estado, vent, alarma} !== 4'b0110) begin
      $display("FAIL alarm_setup: got %b expected %b", {estado, vent, alarma}, 4'b0110);
    end else passed++;
    for (int i = 0; i < 4; i++) begin
      exp_s = (i == 3) ? 4'b1001 : 4'b0110;
      cycle(1'b1, 26, 1'b0);
      checks++;
      if ({estado, vent, alarma} !== exp_s) begin
        $display("FAIL alarm_entry sample %0d: got %b expected %b", i + 1, {estado, vent, alarma}, exp_s);
      end else passed++;
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, hot[i], 1'b0);
      checks++;
      if ({estado, vent, alarma} !== 4'b1001) begin
        $display("FAIL alarm_hold sample %0d: got %b expected %b", i + 1, {estado, vent, alarma}, 4'b1001);
      end else passed++;
    end
  endtask

  task automatic test_ack();
    cycle(1'b1, 28, 1'b1);
    checks++;
    if ({estado, vent, alarma} !== 4'b1001) begin
      $display("FAIL ack_hot: got %b expected %b", {estado, vent, alarma}, 4'b1001);
    end else passed++;
    cycle(1'b0, 25, 1'b1);
    checks++;
    if ({estado, vent, alarma} !== 4'b1001) begin
      $display("FAIL ack_no_sample: got %b expected %b", {estado, vent, alarma}, 4'b1001);
    end else passed++;
    cycle(1'b1, 25, 1'b1);
    checks++;
    if ({estado, vent, alarma, dut.cnt_sube, dut.cnt_baja} !== 10'b0110_000_000) begin
      $display("FAIL ack_exit: got %b expected %b", {estado, vent, alarma, dut.cnt_sube, dut.cnt_baja}, 10'b0110_000_000);
    end else passed++;
  endtask

  task automatic test_reset_async();
    repeat (4) cycle(1'b1, 27, 1'b0);
    checks++;
    if ({estado, vent, alarma} !== 4'b1001) begin
      $display("FAIL reset_async_setup: got %b expected %b", {estado, vent, alarma}, 4'b1001);
    end else passed++;
    muestra = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({estado, vent, alarma, dut.cnt_sube, dut.cnt_baja} !== 10'b0) begin
      $display("FAIL reset_async_mid_cycle: got %b expected %b", {estado, vent, alarma, dut.cnt_sube, dut.cnt_baja}, 10'b0);
    end else passed++;
    #1 reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 0, 1'b0);
      checks++;
      if ({estado, vent, alarma} !== 4'b0000) begin
        $display("FAIL reset_release cycle %0d: got %b expected %b", i, {estado, vent, alarma}, 4'b0000);
      end else passed++;
    end
  endtask

  task automatic test_back_to_back_n1();
    int unsigned seq[8]  = '{19, 20, 18, 17, 20, 26, 26, 25};
    bit          ack[8]  = '{0, 0, 0, 0, 0, 0, 1, 1};
    logic [3:0]  exp[8]  = '{4'b0000, 4'b0110, 4'b0110, 4'b0000, 4'b0110, 4'b1001, 4'b1001, 4'b0110};
    muestra = 1'b0;
    for (int i = 0; i < 8; i++) begin
      muestra1 = 1'b1;
      temp1    = seq[i][W-1:0];
      acuse1   = ack[i];
      @(posedge clk);
      #1;
      checks++;
      if ({estado1, vent1, alarma1} !== exp[i]) begin
        $display("FAIL n_conf1 sample %0d (temp=%0d): got %b expected %b", i + 1, seq[i], {estado1, vent1, alarma1}, exp[i]);
      end else passed++;
    end
    muestra1 = 1'b0;
  endtask

  task automatic test_illegal_state();
    repeat (4) cycle(1'b1, 22, 1'b0);
    repeat (2) cycle(1'b1, 26, 1'b0);
    muestra = 1'b0;
    force dut.estado = 2'b11;
    @(posedge clk);
    #1;
    release dut.estado;
    @(posedge clk);
    #1;
    model_reset();
    checks++;
    if ({estado, vent, alarma, dut.cnt_sube, dut.cnt_baja} !== 10'b0) begin
      $display("FAIL illegal_state_recovery: got %b expected %b", {estado, vent, alarma, dut.cnt_sube, dut.cnt_baja}, 10'b0);
    end else passed++;
  endtask

  task automatic test_random();
    int unsigned band = 0;
    int unsigned t;
    bit          m, a;
    logic [1:0]  e_st;
    logic [2:0]  e_up, e_dn;
    logic [9:0]  e_all;
    for (int i = 0; i < 800; i++) begin
      if (i % 8 == 0) band = $urandom_range(0, 3);
      case (band)
        0:       t = $urandom_range(0, 17);
        1:       t = $urandom_range(18, 19);
        2:       t = $urandom_range(20, 25);
        default: t = $urandom_range(26, 31);
      endcase
      m = ($urandom_range(0, 9) < 8);
      a = ($urandom_range(0, 3) == 0);
      cycle(m, t, a);
      e_st = (m_mode == 1) ? 2'b01 : (m_mode == 2) ? 2'b10 : 2'b00;
      e_up = (m_mode == 0) ? 3'(run_len(0, N)) : (m_mode == 1) ? 3'(run_len(1, N)) : 3'd0;
      e_dn = (m_mode == 1) ? 3'(run_len(2, N)) : 3'd0;
      e_all = {e_st, m_mode == 1, m_mode == 2, e_up, e_dn};
      checks++;
      if ({estado, vent, alarma, dut.cnt_sube, dut.cnt_baja} !== e_all) begin
        $display("FAIL random cycle %0d (m=%0d t=%0d a=%0d): got %b expected %b",
                 i, m, t, a, {estado, vent, alarma, dut.cnt_sube, dut.cnt_baja}, e_all);
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_turn_on();
    test_hysteresis();
    test_alarm();
    test_ack();
    test_reset_async();
    test_back_to_back_n1();
    test_illegal_state();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
